// File: rtl/router_reg.sv
// router_reg: packet register stage feeding router_fifo (header capture, full-byte parking, parity check)
//   clk, resetn            clock, asynchronous active-low reset
//   pkt_valid, data_in     source byte stream; pkt_valid falling marks the parity byte
//   fifo_full              full flag of the selected router_fifo
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg   FSM state strobes
//   dout                   byte to router_fifo datain
//   parity_done            parity byte captured
//   low_pkt_valid          pkt_valid dropped during load
//   err                    parity mismatch for the current packet
module router_reg #(
    parameter int         DATA_WIDTH   = 8,
    parameter logic [1:0] INVALID_ADDR = 2'b11
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] hdr_byte_q, hdr_byte_d;
    logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
    logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
    logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;
    logic                  err_q, err_d;
    logic                  par_cap;

    always_comb begin
        hdr_byte_d      = (detect_add && pkt_valid && data_in[1:0] != INVALID_ADDR) ? data_in : hdr_byte_q;
        dout_d          = lfd_state                ? hdr_byte_q  :
                          (ld_state && !fifo_full) ? data_in     :
                          laf_state                ? full_byte_q : dout_q;
        // byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL
        full_byte_d     = (ld_state && fifo_full) ? data_in : full_byte_q;
        int_parity_d    = detect_add                              ? '0                         :
                          lfd_state                               ? int_parity_q ^ hdr_byte_q :
                          (ld_state && pkt_valid && !full_state)  ? int_parity_q ^ data_in    : int_parity_q;
        // parity byte lands either directly, or after a full stall (source holds it on data_in)
        par_cap         = (ld_state && !fifo_full && !pkt_valid) ||
                          (laf_state && low_pkt_valid_q && !parity_done_q);
        pkt_parity_d    = par_cap ? data_in : pkt_parity_q;
        parity_done_d   = detect_add ? 1'b0 : par_cap ? 1'b1 : parity_done_q;
        low_pkt_valid_d = (ld_state && !pkt_valid) ? 1'b1 : rst_int_reg ? 1'b0 : low_pkt_valid_q;
        err_d           = detect_add ? 1'b0 : parity_done_q ? (int_parity_q != pkt_parity_q) : err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q          <= '0;
            hdr_byte_q      <= '0;
            full_byte_q     <= '0;
            int_parity_q    <= '0;
            pkt_parity_q    <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            dout_q          <= dout_d;
            hdr_byte_q      <= hdr_byte_d;
            full_byte_q     <= full_byte_d;
            int_parity_q    <= int_parity_d;
            pkt_parity_q    <= pkt_parity_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: self-checking bench for router_reg driving FSM-style strobe sequences
module tb_router_reg;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       fifo_full = 1'b0;
    logic       detect_add = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl[$];
    bit         fm[$];

    router_reg dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one packet; the model is packet-level: dout follows the byte stream,
    // parity is the XOR of header and payload, err is (computed != supplied).
    task automatic pkt(input logic [7:0] hdr, input logic [7:0] par, input bit par_full);
        logic [7:0] exp_par;
        logic [7:0] prev;
        exp_par = hdr;
        prev = hdr;
        detect_add = 1; pkt_valid = 1; data_in = hdr;
        tick();
        detect_add = 0;
        checks++;
        if (err !== 1'b0 || parity_done !== 1'b0) begin
            errors++;
            $display("FAIL hdr_clear: err=%b parity_done=%b expected 0 0", err, parity_done);
        end
        lfd_state = 1;
        tick();
        lfd_state = 0;
        checks++;
        if (dout !== hdr) begin
            errors++;
            $display("FAIL lfd_dout: dout=%h expected %h", dout, hdr);
        end
        foreach (pl[i]) begin
            data_in = pl[i];
            exp_par ^= pl[i];
            if (fm[i]) begin
                ld_state = 1; fifo_full = 1;
                tick();
                ld_state = 0;
                checks++;
                if (dout !== prev) begin
                    errors++;
                    $display("FAIL full_hold: dout=%h expected %h", dout, prev);
                end
                full_state = 1;
                tick();
                full_state = 0; fifo_full = 0; laf_state = 1;
                tick();
                laf_state = 0;
            end else begin
                ld_state = 1;
                tick();
                ld_state = 0;
            end
            checks++;
            if (dout !== pl[i]) begin
                errors++;
                $display("FAIL payload_dout[%0d]: dout=%h expected %h", i, dout, pl[i]);
            end
            prev = pl[i];
        end
        data_in = par; pkt_valid = 0;
        if (par_full) begin
            ld_state = 1; fifo_full = 1;
            tick();
            ld_state = 0;
            checks++;
            if (dout !== prev || parity_done !== 1'b0 || low_pkt_valid !== 1'b1) begin
                errors++;
                $display("FAIL par_park: dout=%h pd=%b low=%b expected %h 0 1", dout, parity_done, low_pkt_valid, prev);
            end
            full_state = 1;
            tick();
            full_state = 0; fifo_full = 0; laf_state = 1;
            tick();
            laf_state = 0;
        end else begin
            ld_state = 1;
            tick();
            ld_state = 0;
        end
        checks++;
        if (dout !== par || parity_done !== 1'b1 || low_pkt_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL par_done: dout=%h pd=%b low=%b err=%b expected %h 1 1 0", dout, parity_done, low_pkt_valid, err, par);
        end
        rst_int_reg = 1;
        tick();
        rst_int_reg = 0;
        checks++;
        if (err !== (exp_par != par) || low_pkt_valid !== 1'b0 || parity_done !== 1'b1) begin
            errors++;
            $display("FAIL err_check: err=%b low=%b pd=%b expected %b 0 1", err, low_pkt_valid, parity_done, exp_par != par);
        end
        tick();
    endtask

    task automatic test_reset();
        resetn = 0;
        tick();
        checks++;
        if (dout !== 8'h00 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dout=%h pd=%b low=%b err=%b expected 00 0 0 0", dout, parity_done, low_pkt_valid, err);
        end
        resetn = 1;
        tick();
        detect_add = 1; pkt_valid = 1; data_in = 8'hA5;
        tick();
        detect_add = 0; lfd_state = 1;
        tick();
        lfd_state = 0; ld_state = 1; pkt_valid = 0; data_in = 8'hA5; fifo_full = 1;
        tick();
        ld_state = 0; fifo_full = 0;
        checks++;
        if (dout !== 8'hA5 || low_pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: dout=%h low=%b expected a5 1", dout, low_pkt_valid);
        end
        resetn = 0;
        #2;
        checks++;
        if (dout !== 8'h00 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout=%h pd=%b low=%b err=%b expected 00 0 0 0", dout, parity_done, low_pkt_valid, err);
        end
        tick();
        resetn = 1;
        tick();
    endtask

    task automatic test_good_packet();
        pl = '{8'h01, 8'h02, 8'h03};
        fm = '{0, 0, 0};
        pkt(8'h0D, 8'h0D, 0);
    endtask

    task automatic test_bad_parity();
        pl = '{8'h01, 8'h02, 8'h03};
        fm = '{0, 0, 0};
        pkt(8'h0D, 8'h0C, 0);
        detect_add = 1; pkt_valid = 1; data_in = 8'h0D;
        tick();
        detect_add = 0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0", err);
        end
        tick();
    endtask

    task automatic test_fifo_full();
        pl = '{8'h11, 8'h55, 8'h22};
        fm = '{0, 1, 0};
        pkt(8'h0D, 8'h0D ^ 8'h11 ^ 8'h55 ^ 8'h22, 0);
        pl = '{8'h11, 8'h55, 8'h22};
        pkt(8'h0D, 8'h0D ^ 8'h11 ^ 8'h22, 1);
    endtask

    task automatic test_invalid_addr();
        pl = '{8'h01};
        fm = '{0};
        pkt(8'h0E, 8'h0F, 0);
        detect_add = 1; pkt_valid = 1; data_in = 8'h47;
        tick();
        detect_add = 0; lfd_state = 1;
        tick();
        lfd_state = 0;
        checks++;
        if (dout !== 8'h0E) begin
            errors++;
            $display("FAIL invalid_addr: dout=%h expected 0e", dout);
        end
        tick();
    endtask

    task automatic test_low_pkt_clear();
        pl = '{8'h33, 8'h44};
        fm = '{0, 0};
        pkt(8'h12, 8'h00, 0);
        tick();
        checks++;
        if (parity_done !== 1'b1 || low_pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL pd_hold: pd=%b low=%b expected 1 0", parity_done, low_pkt_valid);
        end
        detect_add = 1; pkt_valid = 1; data_in = 8'h12;
        tick();
        detect_add = 0;
        checks++;
        if (parity_done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL pd_clear: pd=%b err=%b expected 0 0", parity_done, err);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [7:0] hdr;
            logic [7:0] good;
            logic [7:0] par;
            int len;
            hdr = {6'($urandom), 2'($urandom_range(0, 2))};
            len = $urandom_range(1, 6);
            pl.delete();
            fm.delete();
            good = hdr;
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                fm.push_back($urandom_range(0, 3) == 0);
                good ^= pl[i];
            end
            par = $urandom_range(0, 1) ? good : 8'($urandom);
            pkt(hdr, par, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_fifo_full();
        test_invalid_addr();
        test_low_pkt_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
